// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared FP16 constants, FSM encoding and operand sanitizing for perceptron_infer
package perceptron_pkg;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_MAX  = 16'h7BFF;
    localparam logic [15:0] FP16_NMAX = 16'hFBFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC1 = 2'd1,
        MAC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    // Inf/NaN become +/- max finite, subnormals flush to zero.
    function automatic logic [15:0] fp16_sanitize(input logic [15:0] x);
        if (x[14:10] == 5'h1F) return {x[15], FP16_MAX[14:0]};
        if (x[14:10] == 5'h00) return FP16_ZERO;
        return x;
    endfunction

endpackage

// File: rtl/fp16_mul_add.sv
// rtl/fp16_mul_add.sv - combinational FP16 y = a*b + c, exact sum then truncation, saturating, flush-to-zero
module fp16_mul_add
    import perceptron_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    output logic [15:0] y
);
    // Fixed point in units of 2^-48 holds every product and addend exactly.
    localparam int AW = 82;

    logic [15:0]   an, bn, cn;
    logic [10:0]   ma, mb, mc;
    logic [21:0]   pm;
    logic [AW-1:0] prod, addend, mag;
    logic          sp, sgn;
    logic [6:0]    msb;

    assign an = fp16_sanitize(a);
    assign bn = fp16_sanitize(b);
    assign cn = fp16_sanitize(c);
    assign ma = {an[14:10] != 5'd0, an[9:0]};
    assign mb = {bn[14:10] != 5'd0, bn[9:0]};
    assign mc = {cn[14:10] != 5'd0, cn[9:0]};
    assign pm = 22'(ma) * 22'(mb);
    assign sp = an[15] ^ bn[15];

    always_comb begin
        prod   = '0;
        addend = '0;
        if (an[14:10] != 5'd0 && bn[14:10] != 5'd0)
            prod = AW'(pm) << (7'(an[14:10]) + 7'(bn[14:10]) - 7'd2);
        if (cn[14:10] != 5'd0)
            addend = AW'(mc) << (7'(cn[14:10]) + 7'd23);

        if (sp == cn[15]) begin
            mag = prod + addend;
            sgn = sp;
        end else if (prod >= addend) begin
            mag = prod - addend;
            sgn = sp;
        end else begin
            mag = addend - prod;
            sgn = cn[15];
        end

        msb = 7'd0;
        for (int i = 0; i < AW; i++)
            if (mag[i]) msb = 7'(i);

        // Bit 48 is 1.0; msb 34..63 maps to biased exponents 1..30.
        y = FP16_ZERO;
        if (mag != '0) begin
            if (msb > 7'd63)
                y = sgn ? FP16_NMAX : FP16_MAX;
            else if (msb >= 7'd34)
                y = {sgn, 5'(msb - 7'd33), 10'(mag >> (msb - 7'd10))};
        end
    end

endmodule

// File: rtl/perceptron_infer.sv
// rtl/perceptron_infer.sv - FP16 perceptron inference with step activation; PERCEPTRON_ERRCNT_EN adds a label error counter
module perceptron_infer
    import perceptron_pkg::*;
#(
    parameter int TAM = 16
`ifdef PERCEPTRON_ERRCNT_EN
    , parameter int ERR_W = 8
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           w_load,
    input  logic [TAM-1:0] w0,
    input  logic [TAM-1:0] w1,
    input  logic [TAM-1:0] w2,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [TAM-1:0] in1,
    input  logic [TAM-1:0] in2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [TAM-1:0] result,
    output logic [TAM-1:0] net
`ifdef PERCEPTRON_ERRCNT_EN
    ,
    input  logic [TAM-1:0] d,
    output logic [ERR_W-1:0] err_count
`endif
);
    state_t         state, state_nx;
    logic [TAM-1:0] w0_q, w1_q, w2_q, x1_q, x2_q, acc_q, net_q, result_q;
    logic [TAM-1:0] ma_a, ma_b, ma_c, ma_y, act;
    logic           accept;
`ifdef PERCEPTRON_ERRCNT_EN
    logic [TAM-1:0] d_q;
`endif

    assign in_ready  = (state == IDLE) && !w_load && reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign net       = net_q;

    always_comb begin
        ma_a = w2_q;
        ma_b = x2_q;
        ma_c = acc_q;
        if (state == MAC1) begin
            ma_a = w1_q;
            ma_b = x1_q;
            ma_c = w0_q;
        end
    end

    fp16_mul_add u_mac (
        .a (ma_a),
        .b (ma_b),
        .c (ma_c),
        .y (ma_y)
    );

    // -0 counts as non-negative.
    assign act = (!ma_y[15] || ma_y == 16'h8000) ? FP16_ONE : FP16_ZERO;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC1;
            MAC1:    state_nx = MAC2;
            MAC2:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            w0_q     <= FP16_ZERO;
            w1_q     <= FP16_ZERO;
            w2_q     <= FP16_ZERO;
            x1_q     <= FP16_ZERO;
            x2_q     <= FP16_ZERO;
            acc_q    <= FP16_ZERO;
            net_q    <= FP16_ZERO;
            result_q <= FP16_ZERO;
`ifdef PERCEPTRON_ERRCNT_EN
            d_q       <= FP16_ZERO;
            err_count <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && w_load) begin
                w0_q <= w0;
                w1_q <= w1;
                w2_q <= w2;
            end
            if (accept) begin
                x1_q <= in1;
                x2_q <= in2;
`ifdef PERCEPTRON_ERRCNT_EN
                d_q  <= d;
`endif
            end
            if (state == MAC1)
                acc_q <= ma_y;
            if (state == MAC2) begin
                acc_q    <= ma_y;
                net_q    <= ma_y;
                result_q <= act;
`ifdef PERCEPTRON_ERRCNT_EN
                if (act != d_q && err_count != '1)
                    err_count <= err_count + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_perceptron_infer.sv
// tb/tb_perceptron_infer.sv - self-checking bench for perceptron_infer against an exact fixed-point FP16 model
module tb_perceptron_infer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_load = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] w0 = 16'h0, w1 = 16'h0, w2 = 16'h0, in1 = 16'h0, in2 = 16'h0;
    logic        in_ready, out_valid;
    logic [15:0] result, net;
`ifdef PERCEPTRON_ERRCNT_EN
    logic [15:0] d = 16'h0;
    logic [7:0]  err_count;
    int          exp_err = 0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // current weights as seen by the model
    logic [15:0] mw0 = 16'h0, mw1 = 16'h0, mw2 = 16'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perceptron_infer dut (
        .clk       (clk),
        .reset     (reset),
        .w_load    (w_load),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .net       (net)
`ifdef PERCEPTRON_ERRCNT_EN
        ,
        .d         (d),
        .err_count (err_count)
`endif
    );

    typedef logic signed [191:0] wide_t;

    // FP16 value as an exact integer count of 2^-48.
    function automatic wide_t to_units(input logic [15:0] x);
        logic [4:0] e;
        wide_t      m;
        e = x[14:10];
        if (e == 5'd31) begin
            x = {x[15], 15'h7BFF};
            e = 5'd30;
        end
        if (e == 5'd0) return 0;
        m = wide_t'(1024 + int'(x[9:0]));
        m = m <<< (int'(e) + 23);
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] from_units(input wide_t v);
        wide_t mag;
        logic  s;
        int    e;
        if (v == 0) return 16'h0000;
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag < (wide_t'(1) <<< 34)) return 16'h0000;
        if (mag >= (wide_t'(1) <<< 64)) return s ? 16'hFBFF : 16'h7BFF;
        e = 1;
        while (mag >= (wide_t'(1) <<< (e + 34))) e++;
        return {s, 5'(e), 10'((mag >>> (e + 23)) - 1024)};
    endfunction

    function automatic logic [15:0] fma(input logic [15:0] a, b, c);
        return from_units(((to_units(a) * to_units(b)) >>> 48) + to_units(c));
    endfunction

    function automatic logic [15:0] model_net(input logic [15:0] x1, x2);
        return fma(mw2, x2, fma(mw1, x1, mw0));
    endfunction

    function automatic logic [15:0] model_act(input logic [15:0] n);
        return (to_units(n) >= 0) ? 16'h3C00 : 16'h0000;
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       return r;
            1:       return {r[15], ($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00, r[9:0]};
            2:       return {r[15], 15'h0};
            default: return {r[15], 5'($urandom_range(11, 19)), r[9:0]};
        endcase
    endfunction

    task automatic load_w(input logic [15:0] a, b, c);
        @(negedge clk);
        w_load = 1'b1;
        w0 = a; w1 = b; w2 = c;
        @(negedge clk);
        w_load = 1'b0;
        mw0 = a; mw1 = b; mw2 = c;
    endtask

    task automatic do_sample(input logic [15:0] a, b,
                             output logic [15:0] o_net, o_res,
                             output int lat, output int acc_cyc);
        int guard;
        @(negedge clk);
        in1 = a; in2 = b; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        o_net = net;
        o_res = result;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        vectors++;
        if (net !== 16'h0000) begin miscompares++; $display("FAIL reset_net: got %h expected 0000", net); end
        vectors++;
        if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_unit_weights();
        logic [15:0] xa [4] = '{16'h0000, 16'h3C00, 16'h0000, 16'h3C00};
        logic [15:0] xb [4] = '{16'h0000, 16'h0000, 16'h3C00, 16'h3C00};
        logic [15:0] en [4] = '{16'h3C00, 16'h4000, 16'h4000, 16'h4200};
        logic [15:0] n, r;
        int lat, ac;
        load_w(16'h3C00, 16'h3C00, 16'h3C00);
        for (int i = 0; i < 4; i++) begin
            do_sample(xa[i], xb[i], n, r, lat, ac);
            vectors++;
            if (n !== en[i]) begin miscompares++; $display("FAIL unit_net[%0d]: got %h expected %h", i, n, en[i]); end
            vectors++;
            if (r !== 16'h3C00) begin miscompares++; $display("FAIL unit_result[%0d]: got %h expected 3c00", i, r); end
            vectors++;
            if (lat != 3) begin miscompares++; $display("FAIL unit_latency[%0d]: got %0d expected 3", i, lat); end
        end
    endtask

    task automatic test_negative_bias();
        logic [15:0] xa [3] = '{16'h3C00, 16'h3C00, 16'h0000};
        logic [15:0] xb [3] = '{16'h3C00, 16'h0000, 16'h0000};
        logic [15:0] en [3] = '{16'h0000, 16'hB800, 16'hBC00};
        logic [15:0] er [3] = '{16'h3C00, 16'h0000, 16'h0000};
        logic [15:0] n, r;
        int lat, ac;
        load_w(16'hBC00, 16'h3800, 16'h3800);
        for (int i = 0; i < 3; i++) begin
            do_sample(xa[i], xb[i], n, r, lat, ac);
            vectors++;
            if (n !== en[i]) begin miscompares++; $display("FAIL neg_net[%0d]: got %h expected %h", i, n, en[i]); end
            vectors++;
            if (r !== er[i]) begin miscompares++; $display("FAIL neg_result[%0d]: got %h expected %h", i, r, er[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] n, r;
        int lat, ac;
        load_w(16'h0000, 16'h7BFF, 16'h0000);
        do_sample(16'h7BFF, 16'h3C00, n, r, lat, ac);
        vectors++;
        if (n !== 16'h7BFF) begin miscompares++; $display("FAIL sat_net: got %h expected 7bff", n); end
        vectors++;
        if (r !== 16'h3C00) begin miscompares++; $display("FAIL sat_result: got %h expected 3c00", r); end
    endtask

    task automatic test_backpressure();
        logic [15:0] n, r, en2;
        int lat, ac, guard;
        load_w(16'h3C00, 16'h4000, 16'hC000);
        out_ready = 1'b0;
        do_sample(16'h3C00, 16'h0000, n, r, lat, ac);
        vectors++;
        if (n !== model_net(16'h3C00, 16'h0000)) begin miscompares++; $display("FAIL bp_net: got %h expected %h", n, model_net(16'h3C00, 16'h0000)); end
        in1 = 16'h3800; in2 = 16'h3C00; in_valid = 1'b1;
        en2 = model_net(16'h3800, 16'h3C00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || net !== n || result !== r || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b net=%h result=%h in_ready=%b expected 1/%h/%h/0",
                         i, out_valid, net, result, in_ready, n, r);
            end
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        vectors++;
        if (net !== en2) begin miscompares++; $display("FAIL bp_next_net: got %h expected %h", net, en2); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] n, r;
        int lat, ac1, ac2;
        do_sample(16'h3C00, 16'h3C00, n, r, lat, ac1);
        do_sample(16'h4000, 16'h3800, n, r, lat, ac2);
        vectors++;
        if (ac2 - ac1 != 4) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 4", ac2 - ac1); end
        vectors++;
        if (n !== model_net(16'h4000, 16'h3800)) begin miscompares++; $display("FAIL b2b_net: got %h expected %h", n, model_net(16'h4000, 16'h3800)); end
    endtask

    task automatic test_wload_priority();
        int guard;
        @(negedge clk);
        w_load = 1'b1;
        w0 = 16'h3C00; w1 = 16'h4000; w2 = 16'hC000;
        in1 = 16'h3C00; in2 = 16'h3800; in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL wload_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        w_load = 1'b0;
        mw0 = 16'h3C00; mw1 = 16'h4000; mw2 = 16'hC000;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wload_next_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        vectors++;
        if (net !== 16'h4000) begin miscompares++; $display("FAIL wload_net: got %h expected 4000", net); end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] n, r;
        int lat, ac, seen;
        load_w(16'h3C00, 16'h3C00, 16'h3C00);
        @(negedge clk);
        in1 = 16'h3C00; in2 = 16'h3C00; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL midreset_out_valid: got %0d cycles valid expected 0", seen); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready); end
        reset = 1'b1;
        mw0 = 16'h0; mw1 = 16'h0; mw2 = 16'h0;
        do_sample(16'h3C00, 16'h3C00, n, r, lat, ac);
        vectors++;
        if (n !== 16'h0000) begin miscompares++; $display("FAIL midreset_net: got %h expected 0000", n); end
        vectors++;
        if (r !== 16'h3C00) begin miscompares++; $display("FAIL midreset_result: got %h expected 3c00", r); end
    endtask

`ifdef PERCEPTRON_ERRCNT_EN
    task automatic test_errcnt();
        logic [15:0] xa [4] = '{16'h0000, 16'h3C00, 16'h0000, 16'h3C00};
        logic [15:0] xb [4] = '{16'h0000, 16'h0000, 16'h3C00, 16'h3C00};
        logic [15:0] n, r;
        int lat, ac;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load_w(16'h3C00, 16'h3C00, 16'h3C00);
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 16'h0000 : 16'h3C00;
            do_sample(xa[i], xb[i], n, r, lat, ac);
        end
        exp_err = 1;
        vectors++;
        if (err_count !== 8'd1) begin miscompares++; $display("FAIL errcnt: got %0d expected 1", err_count); end
    endtask
`endif

    task automatic test_random();
        logic [15:0] a, b, n, r, en;
        int lat, ac;
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) load_w(rand_fp16(), rand_fp16(), rand_fp16());
            a = rand_fp16();
            b = rand_fp16();
            en = model_net(a, b);
`ifdef PERCEPTRON_ERRCNT_EN
            d = ($urandom_range(0, 1) != 0) ? 16'h3C00 : 16'h0000;
            if (model_act(en) != d && exp_err < 255) exp_err++;
`endif
            do_sample(a, b, n, r, lat, ac);
            vectors++;
            if (n !== en) begin
                miscompares++;
                $display("FAIL rand_net[%0d]: w=%h/%h/%h in=%h/%h got %h expected %h", i, mw0, mw1, mw2, a, b, n, en);
            end
            vectors++;
            if (r !== model_act(en)) begin miscompares++; $display("FAIL rand_result[%0d]: got %h expected %h", i, r, model_act(en)); end
        end
`ifdef PERCEPTRON_ERRCNT_EN
        vectors++;
        if (err_count !== 8'(exp_err)) begin miscompares++; $display("FAIL rand_errcnt: got %0d expected %0d", err_count, exp_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_unit_weights();
        test_negative_bias();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_wload_priority();
        test_reset_midflight();
`ifdef PERCEPTRON_ERRCNT_EN
        test_errcnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
